r5p_mem_rsp: RTL and testbench

Single-port memory responder for the r5p load/store and instruction-fetch buses: the target-side counterpart of the core's bus initiator. Accepts `req/wen/adr/ben/wdt` transfers, inserts a configurable number of wait states before `ack`, performs byte-enabled writes into an internal word array and returns read data one cycle after the acknowledged transfer. It serves as the testbench and FPGA memory behind either core bus port.

---
 rtl/r5p_mem_rsp_if.sv | 21 ++
 rtl/r5p_mem_rsp.sv | 89 ++++++++
 tb/tb_r5p_mem_rsp.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/r5p_mem_rsp_if.sv
// r5p memory bus bundle: one request/acknowledge transfer channel.
//   req/wen/adr/ben/wdt : initiator -> target (held stable while req & ~ack)
//   rdt/ack             : target -> initiator
// Modports: master (core/testbench side), slave (memory responder side).
interface r5p_mem_rsp_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW/8;

  logic          req;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          ack;

  modport master (output req, wen, adr, ben, wdt, input  rdt, ack);
  modport slave  (input  req, wen, adr, ben, wdt, output rdt, ack);
endinterface

// File: rtl/r5p_mem_rsp.sv
// r5p_mem_rsp: single-port memory responder for the r5p fetch/load-store bus.
// Inserts tgt wait states before ack, does byte-enabled writes, returns read
// data on rdt one cycle after the acknowledged read.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - r5p_mem_rsp_if.slave (req, wen, adr, ben, wdt in; rdt, ack out)
// Optional feature macro: R5P_MEM_RSP_RAND_EN -- per-transfer random wait count
// min(lfsr[7:0], WAIT) from a 16-bit Galois LFSR; otherwise tgt == WAIT.
module r5p_mem_rsp #(
  parameter int          AW   = 32,
  parameter int          DW   = 32,
  parameter int          BW   = DW/8,
  parameter int          SIZE = 16384,
  parameter int          WAIT = 0,
  parameter logic [15:0] SEED = 16'hACE1
)(
  input  logic              clk,
  input  logic              rst,
  r5p_mem_rsp_if.slave      bus
);

  localparam int          AB   = $clog2(SIZE);
  localparam int          OB   = $clog2(BW);
  localparam int          WRDS = SIZE/BW;
  localparam logic [7:0]  WMAX = 8'(WAIT);

  logic [DW-1:0]    mem [WRDS];
  logic [AB-OB-1:0] idx;
  logic [7:0]       cnt;
  logic [7:0]       tgt;
  logic             ack;
  logic             xfer;

  // Upper address bits and byte offset are dropped: addresses wrap mod SIZE.
  assign idx     = bus.adr[AB-1:OB];
  assign ack     = bus.req & (cnt == tgt);
  assign xfer    = bus.req & ack;
  assign bus.ack = ack;

`ifdef R5P_MEM_RSP_RAND_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  function automatic logic [7:0] clip(input logic [7:0] v);
    return (v > WMAX) ? WMAX : v;
  endfunction

  // Right-shift Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Advances only on completed transfers so the wait pattern is a function
  // of the transfer sequence, not of idle or aborted cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
      tgt  <= clip(SEED[7:0]);
    end else if (xfer) begin
      lfsr <= lfsr_nxt;
      tgt  <= clip(lfsr_nxt[7:0]);
    end
  end
`else
  assign tgt = WMAX;
`endif

  // Wait counter: counts while a request is pending, clears on completion or
  // when req drops (abort).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (bus.req & ~ack) cnt <= cnt + 8'd1;
    else                     cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 bus.rdt <= '0;
    else if (xfer & ~bus.wen) bus.rdt <= mem[idx];
  end

  // Storage is not reset. The rst term keeps a zero-wait write that is
  // acknowledged while reset is asserted from landing in the array.
  always_ff @(posedge clk) begin
    if (xfer & bus.wen & ~rst) begin
      for (int i = 0; i < BW; i++)
        if (bus.ben[i]) mem[idx][i*8 +: 8] <= bus.wdt[i*8 +: 8];
    end
  end

endmodule

// File: tb/tb_r5p_mem_rsp.sv
// Directed bench for r5p_mem_rsp: three responders (WAIT = 0, 3, 7) share the
// address/data lines, each with its own req. Inputs change 1ns after posedge,
// outputs are sampled on negedge.
module tb_r5p_mem_rsp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic        wen = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  ben = '0;
  logic [31:0] wdt = '0;
  logic [2:0]  ackv;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  r5p_mem_rsp_if #(.AW(32), .DW(32)) b0 ();
  r5p_mem_rsp_if #(.AW(32), .DW(32)) b3 ();
  r5p_mem_rsp_if #(.AW(32), .DW(32)) b7 ();

  assign b0.req = req[0]; assign b0.wen = wen; assign b0.adr = adr; assign b0.ben = ben; assign b0.wdt = wdt;
  assign b3.req = req[1]; assign b3.wen = wen; assign b3.adr = adr; assign b3.ben = ben; assign b3.wdt = wdt;
  assign b7.req = req[2]; assign b7.wen = wen; assign b7.adr = adr; assign b7.ben = ben; assign b7.wdt = wdt;
  assign ackv = {b7.ack, b3.ack, b0.ack};

  r5p_mem_rsp #(.WAIT(0))                   u0 (.clk(clk), .rst(rst), .bus(b0));
  r5p_mem_rsp #(.WAIT(3))                   u3 (.clk(clk), .rst(rst), .bus(b3));
  r5p_mem_rsp #(.WAIT(7), .SEED(16'hACE1))  u7 (.clk(clk), .rst(rst), .bus(b7));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a transfer on bus s, counts wait cycles until ack, returns 1ns
  // after the completing edge with req still high (caller decides next).
  task automatic xfer(input int s, input logic w, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] d, output int lat);
    wen = w; adr = a; ben = be; wdt = d; req[s] = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (ackv[s]) break;
      lat++;
      if (lat > 300) begin
        chk("ack_timeout", 32'(lat), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    req = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

`ifdef R5P_MEM_RSP_RAND_EN
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  int lat_run1 [100];
`endif

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdt0", b0.rdt, 32'h0);
    chk("rst_rdt3", b3.rdt, 32'h0);
    chk("rst_ack0", {31'd0, b0.ack}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait full write then read
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat); req = '0;
    chk("w0_lat", 32'(lat), 32'd0);
    xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, lat); req = '0;
    chk("r0_lat", 32'(lat), 32'd0);
    chk("r0_rdt", b0.rdt, 32'hDEADBEEF);

    // partial write, rdt must hold the previous read across a write
    xfer(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, lat); req = '0;
    chk("pw_rdt_hold", b0.rdt, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, lat); req = '0;
    chk("pw_rdt", b0.rdt, 32'hDE22BE44);

    // aliasing modulo SIZE and ignored byte offset
    xfer(0, 1'b1, 32'h0000_4008, 4'hF, 32'hCAFEF00D, lat); req = '0;
    xfer(0, 1'b0, 32'h0000_0008, 4'h0, 32'h0, lat); req = '0;
    chk("alias_rdt", b0.rdt, 32'hCAFEF00D);
    xfer(0, 1'b0, 32'h8000_000B, 4'h0, 32'h0, lat); req = '0;
    chk("alias_hi_rdt", b0.rdt, 32'hCAFEF00D);

    // read in the cycle right after a write to the same word, 1/cycle
    xfer(0, 1'b1, 32'h20, 4'hF, 32'h12345678, lat);
    xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, lat); req = '0;
    chk("b2b0_lat", 32'(lat), 32'd0);
    chk("raw_rdt", b0.rdt, 32'h12345678);

`ifndef R5P_MEM_RSP_RAND_EN
    // fixed 3 wait states, back-to-back pays the full wait again
    xfer(1, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, lat);
    chk("w3_lat", 32'(lat), 32'd3);
    xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, lat); req = '0;
    chk("r3_b2b_lat", 32'(lat), 32'd3);
    chk("r3_rdt", b3.rdt, 32'hA5A5A5A5);

    // abort: req dropped before ack leaves memory untouched
    xfer(1, 1'b1, 32'h4, 4'hF, 32'h11111111, lat); req = '0;
    wen = 1'b1; adr = 32'h4; wdt = 32'h22222222; req[1] = 1'b1;
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h4, 4'hF, 32'h0, lat); req = '0;
    chk("abort_lat", 32'(lat), 32'd3);
    chk("abort_rdt", b3.rdt, 32'h11111111);

    // reset at cnt==2 of a write
    wen = 1'b1; adr = 32'h0; ben = 4'hF; wdt = 32'hFFFFFFFF; req[1] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_mid_noack", {31'd0, b3.ack}, 32'h0);
    rst = 1'b1;
    #1 chk("rst_mid_ack", {31'd0, b3.ack}, 32'h0);
    req = '0;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_mid_rdt3", b3.rdt, 32'h0);
    chk("rst_mid_rdt0", b0.rdt, 32'h0);
    // full 3-cycle wait again shows cnt restarted from 0
    xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, lat); req = '0;
    chk("rst_mid_lat", 32'(lat), 32'd3);
    chk("rst_mid_mem", b3.rdt, 32'hA5A5A5A5);
`else
    // random waits: two runs from reset must follow the reference LFSR
    for (int run = 0; run < 2; run++) begin
      logic [15:0] m;
      logic [7:0]  e;
      rst_pulse();
      m = 16'hACE1;
      for (int k = 0; k < 100; k++) begin
        e = (m[7:0] > 8'd7) ? 8'd7 : m[7:0];
        xfer(2, 1'b0, 32'(k*4), 4'hF, 32'h0, lat);
        if (k[0]) req = '0;
        if (lat > 7) chk("rand_lat_max", 32'(lat), 32'd7);
        chk("rand_lat_model", 32'(lat), {24'd0, e});
        if (run == 0) lat_run1[k] = lat;
        else          chk("rand_repeat", 32'(lat), 32'(lat_run1[k]));
        m = lfsr_step(m);
      end
      req = '0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
